// File: rtl/wb_sdram_bridge_if.sv
// Wishbone slave side plus SDRAM controller command side of the bridge.
// The bridge connects through the slave modport. The surrounding bus fabric
// and controller (or a bench) connect through the master modport.
interface wb_sdram_bridge_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 2
);
    logic              wb_cyc;
    logic              wb_stb;
    logic [ADDR_W-1:0] wb_adr;
    logic              wb_we;
    logic [DATA_W-1:0] wb_i_dat;
    logic [SEL_W-1:0]  wb_sel;
    logic [DATA_W-1:0] wb_o_dat;
    logic              wb_ack;
    logic              wb_err;

    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data_in;
    logic [SEL_W-1:0]  c_addr_sel;
    logic              c_read_req;
    logic              c_write_req;
    logic              c_busy;
    logic              c_cack;
    logic              c_read_ready;
    logic [31:0]       c_data_out;

    modport slave (
        input  wb_cyc, wb_stb, wb_adr, wb_we, wb_i_dat, wb_sel,
        output wb_o_dat, wb_ack, wb_err,
        output c_addr, c_data_in, c_addr_sel, c_read_req, c_write_req,
        input  c_busy, c_cack, c_read_ready, c_data_out
    );

    modport master (
        output wb_cyc, wb_stb, wb_adr, wb_we, wb_i_dat, wb_sel,
        input  wb_o_dat, wb_ack, wb_err,
        input  c_addr, c_data_in, c_addr_sel, c_read_req, c_write_req,
        output c_busy, c_cack, c_read_ready, c_data_out
    );
endinterface

// File: rtl/wb_sdram_bridge.sv
// Wishbone slave to SDRAM controller bridge.
// Decodes the SDRAM window, issues one held request per access, and captures
// read data. Returns registered ack/err pulses. A watchdog converts a stalled
// controller into wb_err.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a window hit while the controller is not busy
// REQ     | read or write request held until c_cack
// WAIT_RD | read accepted, waiting for c_read_ready
// DRAIN   | master left during a read, swallow the late read data
// ACK     | wb_ack is high for this single cycle
module wb_sdram_bridge #(
    parameter int                ADDR_W  = 24,
    parameter int                DATA_W  = 16,
    parameter int                SEL_W   = 2,
    parameter logic [ADDR_W-1:0] BASE    = 24'h100000,
    parameter logic [ADDR_W-1:0] LAST    = 24'hffdfff,
    parameter int                TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    wb_sdram_bridge_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT_RD = 3'd2,
        DRAIN   = 3'd3,
        ACK     = 3'd4
    } state_t;

    // r_cnt holds the number of cycles already spent in the access.
    // The access times out on its TIMEOUT-th cycle, so the request is high
    // for exactly TIMEOUT cycles before wb_err.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dat_in;
    logic [SEL_W-1:0]  r_sel;
    logic              r_rd_req;
    logic              r_wr_req;
    logic              r_ack;
    logic              r_err;
    logic [DATA_W-1:0] r_odat;

    logic w_hit;
    logic w_timeout;
    logic w_issue;
    logic w_drop;
    logic w_capture;
    logic w_err_set;
    logic w_unused_hi;

    assign w_hit = bus.wb_cyc && bus.wb_stb &&
                   (bus.wb_adr >= BASE) && (bus.wb_adr <= LAST);
    assign w_timeout   = (r_cnt == TO_LAST);
    assign w_unused_hi = ^bus.c_data_out[31:DATA_W];

    // Next-state and strobe decode. Controller handshakes outrank the timeout.
    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_drop    = 1'b0;
        w_capture = 1'b0;
        w_err_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit && !bus.c_busy) begin
                    w_issue = 1'b1;
                    w_next  = REQ;
                end
            end
            REQ: begin
                if (bus.c_cack && r_we) begin
                    w_drop = 1'b1;
                    w_next = ACK;
                end else if (bus.c_cack && bus.c_read_ready) begin
                    w_drop    = 1'b1;
                    w_capture = 1'b1;
                    w_next    = ACK;
                end else if (bus.c_cack) begin
                    w_drop = 1'b1;
                    w_next = WAIT_RD;
                end else if (!bus.wb_cyc) begin
                    w_drop = 1'b1;
                    w_next = IDLE;
                end else if (w_timeout) begin
                    w_drop    = 1'b1;
                    w_err_set = 1'b1;
                    w_next    = IDLE;
                end
            end
            WAIT_RD: begin
                if (bus.c_read_ready) begin
                    w_capture = 1'b1;
                    w_next    = ACK;
                end else if (w_timeout) begin
                    // Nobody is listening once the cycle has ended, so stay quiet.
                    w_err_set = bus.wb_cyc;
                    w_next    = IDLE;
                end else if (!bus.wb_cyc) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.c_read_ready || w_timeout) begin
                    w_next = IDLE;
                end
            end
            ACK: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register and watchdog counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_cnt <= 8'd0;
            end else if (r_state == REQ || r_state == WAIT_RD || r_state == DRAIN) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Command latch, held stable for the controller until the next issue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_dat_in <= '0;
            r_sel    <= '0;
        end else if (w_issue) begin
            r_we     <= bus.wb_we;
            r_addr   <= bus.wb_adr;
            r_dat_in <= bus.wb_i_dat;
            r_sel    <= bus.wb_sel;
        end
    end

    // Request lines and registered bus responses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_odat   <= '0;
        end else begin
            if (w_issue) begin
                r_rd_req <= !bus.wb_we;
                r_wr_req <= bus.wb_we;
            end else if (w_drop) begin
                r_rd_req <= 1'b0;
                r_wr_req <= 1'b0;
            end
            r_ack <= (w_next == ACK);
            r_err <= w_err_set;
            if (w_capture) begin
                r_odat <= bus.c_data_out[DATA_W-1:0];
            end
        end
    end

    assign bus.c_addr      = r_addr;
    assign bus.c_data_in   = r_dat_in;
    assign bus.c_addr_sel  = r_sel;
    assign bus.c_read_req  = r_rd_req;
    assign bus.c_write_req = r_wr_req;
    assign bus.wb_ack      = r_ack;
    assign bus.wb_err      = r_err;
    assign bus.wb_o_dat    = r_odat;

endmodule
